uart_tx_core: RTL and testbench

Byte-wide UART transmitter, the transmit-side counterpart of the existing 9600-bps receive path. It accepts a parallel byte through a valid/ready handshake and serialises it LSB-first on a single line: start bit, data bits, optional parity, then stop bit(s). It carries its own bit-period counter, so no external baud block is needed. It sits between the user logic and the TX pin of the board.

---
 rtl/uart_tx_core.sv | 119 +++++++++++
 tb/tb_uart_tx_core.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// uart_tx_core: byte-wide UART transmitter with built-in bit-period counter.
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-high reset
//   TX_En      request strobe; a byte is accepted when TX_En && TX_Ready
//   TX_Data    byte to send, sampled only at acceptance
//   TX_Ready   high only in IDLE, when a new byte can be accepted
//   TX_Done    one-cycle pulse when the last stop bit completes
//   TX_Pin_Out serial line, idle high, LSB first
module uart_tx_core #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TX_En,
    input  logic [DATA_BITS-1:0] TX_Data,
    output logic                 TX_Ready,
    output logic                 TX_Done,
    output logic                 TX_Pin_Out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 pin_q, pin_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 wrap;
    always_comb begin
        wrap     = cnt_q == CW'(CLKS_PER_BIT - 1);
        state_d  = state_q;
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pin_d    = pin_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                ready_d = 1'b1;
                pin_d   = 1'b1;
                if (TX_En) begin
                    state_d  = START;
                    shift_d  = TX_Data;
                    parity_d = ^TX_Data ^ PARITY_ODD;
                    ready_d  = 1'b0;
                    pin_d    = 1'b0;
                end
            end
            START: if (wrap) begin
                // the next line level is presented as the register shifts out
                state_d = DATA;
                idx_d   = '0;
                pin_d   = shift_q[0];
                shift_d = shift_q >> 1;
            end
            DATA: if (wrap) begin
                if (idx_q == IW'(DATA_BITS - 1)) begin
                    idx_d   = '0;
                    state_d = PARITY_EN ? PARITY : STOP;
                    pin_d   = PARITY_EN ? parity_q : 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    pin_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: if (wrap) begin
                state_d = STOP;
                pin_d   = 1'b1;
            end
            STOP: if (wrap) begin
                // idx_q counts completed stop bits
                if (idx_q == IW'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            pin_q    <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            pin_q    <= pin_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end
    assign TX_Ready   = ready_q;
    assign TX_Done    = done_q;
    assign TX_Pin_Out = pin_q;
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: checks four transmitter configurations against expected line waveforms.
module tb_uart_tx_core;
    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic [7:0] dat [4];
    wire  [3:0] rdy;
    wire  [3:0] done;
    wire  [3:0] pin;
    int         n_chk;
    int         n_fail;
    int         cper [4];
    bit         pe   [4];
    bit         po   [4];
    int         sb   [4];

    typedef struct {
        int         dut;
        logic [7:0] d;
        string      seq;
        int         poke;
        bit         hold;
    } vec_t;
    vec_t tbl [8];

    uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8n1 (
        .CLK(clk), .RST(rst), .TX_En(en[0]), .TX_Data(dat[0]),
        .TX_Ready(rdy[0]), .TX_Done(done[0]), .TX_Pin_Out(pin[0]));
    uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8e1 (
        .CLK(clk), .RST(rst), .TX_En(en[1]), .TX_Data(dat[1]),
        .TX_Ready(rdy[1]), .TX_Done(done[1]), .TX_Pin_Out(pin[1]));
    uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_8o1 (
        .CLK(clk), .RST(rst), .TX_En(en[2]), .TX_Data(dat[2]),
        .TX_Ready(rdy[2]), .TX_Done(done[2]), .TX_Pin_Out(pin[2]));
    uart_tx_core #(.CLKS_PER_BIT(5208), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_def (
        .CLK(clk), .RST(rst), .TX_En(en[3]), .TX_Data(dat[3]),
        .TX_Ready(rdy[3]), .TX_Done(done[3]), .TX_Pin_Out(pin[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic string model(input logic [7:0] d, input bit p_en, input bit p_odd, input int stops);
        string s;
        int    ones;
        s    = "0";
        ones = $countones(d);
        for (int b = 0; b < 8; b++) begin
            if (d[b]) s = {s, "1"};
            else      s = {s, "0"};
        end
        if (p_en) begin
            if ((ones % 2 == 1) != p_odd) s = {s, "1"};
            else                          s = {s, "0"};
        end
        for (int b = 0; b < stops; b++) s = {s, "1"};
        return s;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after TX_Done.
    task automatic run_frame(input int i, input logic [7:0] d, input string seq,
                             input int poke, input bit hold, input string nm);
        int   c;
        int   n;
        int   cyc;
        int   rlow;
        int   dn;
        bit   bad;
        logic expb;
        logic got;
        c    = cper[i];
        n    = seq.len();
        cyc  = 0;
        rlow = 0;
        dn   = 0;
        chk({nm, " ready before"}, int'(rdy[i]), 1);
        en[i]  = 1'b1;
        dat[i] = d;
        for (int j = 0; j < n; j++) begin
            expb = (seq[j] == "1");
            bad  = 1'b0;
            got  = expb;
            for (int k = 0; k < c; k++) begin
                @(negedge clk);
                cyc++;
                if (pin[i] !== expb && !bad) begin
                    bad = 1'b1;
                    got = pin[i];
                end
                if (rdy[i] !== 1'b1) rlow++;
                if (done[i] !== 1'b0) dn++;
                if (cyc == 1 && !hold) en[i] = 1'b0;
                if (cyc == poke) begin
                    en[i]  = 1'b1;
                    dat[i] = 8'hFF;
                end else if (cyc == poke + 1) begin
                    en[i] = 1'b0;
                end
            end
            chk($sformatf("%s bit%0d", nm, j), int'(got), int'(expb));
        end
        @(negedge clk);
        chk({nm, " ready low cycles"}, rlow, n * c);
        chk({nm, " done inside frame"}, dn, 0);
        chk({nm, " done at end"}, int'(done[i]), 1);
        chk({nm, " ready at end"}, int'(rdy[i]), 1);
        chk({nm, " line after stop"}, int'(pin[i]), 1);
    endtask

    initial begin
        int bad;
        int idle;
        logic [7:0] d;
        n_chk  = 0;
        n_fail = 0;
        cper = '{4, 4, 4, 5208};
        pe   = '{1'b0, 1'b1, 1'b1, 1'b0};
        po   = '{1'b0, 1'b0, 1'b1, 1'b0};
        sb   = '{1, 1, 1, 2};
        tbl[0] = '{0, 8'hA5, "0101001011", -1, 1'b0};
        tbl[1] = '{1, 8'h07, "01110000011", -1, 1'b0};
        tbl[2] = '{2, 8'h07, "01110000001", -1, 1'b0};
        tbl[3] = '{1, 8'h00, "00000000001", -1, 1'b0};
        tbl[4] = '{2, 8'hFF, "01111111111", -1, 1'b0};
        tbl[5] = '{0, 8'h3C, "0001111001", 10, 1'b0};
        tbl[6] = '{0, 8'h81, "0100000011", -1, 1'b1};
        tbl[7] = '{0, 8'h81, "0100000011", -1, 1'b0};
        rst = 1'b1;
        en  = 4'h0;
        for (int i = 0; i < 4; i++) dat[i] = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset pin", int'(pin), 15);
        chk("reset ready", int'(rdy), 15);
        chk("reset done", int'(done), 0);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pin !== 4'hF || rdy !== 4'hF || done !== 4'h0) bad++;
        end
        chk("idle after reset bad cycles", bad, 0);
        for (int t = 0; t < 8; t++)
            run_frame(tbl[t].dut, tbl[t].d, tbl[t].seq, tbl[t].poke, tbl[t].hold, $sformatf("vec%0d", t));
        for (int u = 0; u < 3; u++) begin
            for (int r = 0; r < 8; r++) begin
                d    = 8'($urandom_range(0, 255));
                idle = 1 + $urandom_range(0, 3);
                bad  = 0;
                repeat (idle) begin
                    @(negedge clk);
                    if (pin[u] !== 1'b1 || rdy[u] !== 1'b1 || done[u] !== 1'b0) bad++;
                end
                chk($sformatf("rand u%0d r%0d idle", u, r), bad, 0);
                run_frame(u, d, model(d, pe[u], po[u], sb[u]), -1, 1'b0, $sformatf("rand u%0d d%02h", u, d));
            end
        end
        en[0]  = 1'b1;
        dat[0] = 8'h00;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) en[0] = 1'b0;
        end
        chk("midframe line before reset", int'(pin[0]), 0);
        rst = 1'b1;
        #1;
        chk("midframe async line", int'(pin[0]), 1);
        chk("midframe async ready", int'(rdy[0]), 1);
        chk("midframe async done", int'(done[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (pin[0] !== 1'b1 || done[0] !== 1'b0) bad++;
        end
        chk("after midframe reset bad cycles", bad, 0);
        run_frame(0, 8'h55, "0101010101", -1, 1'b0, "post reset 55");
        run_frame(3, 8'h55, "01010101011", -1, 1'b0, "default 55");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
